agc_datapath: RTL
=================

Name: agc_datapath

Overview:
Datapath counterpart of the AGC state-machine controller. Consumes the controller's mode/adjust/up_dn strobes and returns counter1, counter2, preamble_counter, indicator and done. Owns the detect-window statistics from the RSSI comparators and the registered gain code driven to the analog front end. Sits between the comparator sampler and the controller, one instance per receive chain.

Parameters:
GAIN_W, 6, width of gain code
GAIN_INIT, 32, gain code after reset
GAIN_MIN, 0, lowest legal gain code
GAIN_MAX, 63, highest legal gain code
GAIN_STEP, 1, gain change per adjust step
HI_LIMIT, 3, max "above-high" samples per window still considered in range
LO_LIMIT, 10, max "below-low" samples per window still considered in range

Ports:
clk  in  1  system clock
RESETn  in  1  reset, asynchronous, active-low
sample_valid  in  1  one comparator sample present this cycle
sample_hi  in  1  sample above high threshold
sample_lo  in  1  sample below low threshold
counter1_mode  in  1  enable detect-window counter
counter2_mode  in  1  enable settle counter
preamble_counter_mode  in  1  enable preamble counter; 0 = controller in reset
detect_mode  in  1  accumulate hi/lo statistics
adjust  in  1  adjust phase active
up_dn  in  1  1 = raise gain, 0 = lower gain
counter1  out  4  detect-window sample count
counter2  out  4  settle cycle count
preamble_counter  out  8  preamble sample count
indicator  out  1  1 = last window too strong
done  out  1  sticky lock/terminate flag
gain  out  GAIN_W  registered gain code

Behaviour:
- Reset (async on RESETn low): counter1=0, counter2=0, preamble_counter=0, hi_cnt=lo_cnt=0, indicator=0, done=0, gain=GAIN_INIT. All outputs registered; no combinational input-to-output paths.
- counter1: counter1_mode=0 -> clear to 0 next edge. counter1_mode=1 and sample_valid -> +1, saturating at 15. Window = 15 accepted samples.
- hi_cnt/lo_cnt (internal, 4-bit, saturating): cleared when detect_mode=0. On accepted sample: sample_hi -> hi_cnt+1; else sample_lo -> lo_cnt+1. hi and lo together counts as hi only.
- Window close: the accepted sample that takes counter1 from 14 to 15. On that same edge, from post-increment counts: indicator <= (hi>HI_LIMIT); done <= 1 if hi<=HI_LIMIT and lo<=LO_LIMIT. Controller sees counter1==15 and done in the same cycle; done wins. indicator holds between windows.
- counter2: counter2_mode=0 -> clear. Else +1 every clk (not sample-gated), saturating at 15.
- Gain step: exactly one per adjust phase, on the edge where adjust=1, counter2_mode=1, counter2==0. up_dn=1 -> gain=min(gain+GAIN_STEP, GAIN_MAX); up_dn=0 -> max(gain-GAIN_STEP, GAIN_MIN). Arithmetic at GAIN_W+1 bits, no wrap.
- Rail hit: if the step's requested direction finds gain already at GAIN_MAX/GAIN_MIN, gain unchanged and done <= 1 on that edge.
- preamble_counter: preamble_counter_mode=0 -> clear. Else +1 per sample_valid, saturating at 127 (never reaches 128).
- done: sticky. Cleared only by RESETn or preamble_counter_mode=0. When done=1, gain frozen regardless of adjust.
- Simultaneous clear and count on any counter: clear wins.
- Mid-operation reset: async, all state to reset values; no partial step completes.

Decomposition:
- Package agc_pkg: counter widths (4, 8), terminal counts CNT1_TC=15, CNT2_TC=15, PRE_TC=127, controller state encoding; shared with the controller.
- Sub-module agc_sat_counter (parameter WIDTH, MAX; inputs clr, inc; saturating count). Instantiate for counter1, counter2, preamble_counter, hi_cnt, lo_cnt.

Test Plan:
- Reset: RESETn low mid-count -> all counters 0, done=0, indicator=0, gain=32 immediately (async).
- In-range lock: detect window of 15 samples, 2 hi, 5 lo -> on the 15th-sample edge counter1=15, done=1, indicator=0; gain stays 32.
- Too strong: 15 samples with 8 hi -> indicator=1, done=0; adjust phase with up_dn=0 for 16 clks -> gain 31 (single step), counter2 saturates at 15.
- Too weak: 15 samples with 12 lo -> indicator=0; adjust with up_dn=1 -> gain 33; second window then adjust -> gain 34.
- Rail: GAIN_INIT=63, window 12 lo, adjust up_dn=1 -> gain stays 63, done=1; further adjust strobes leave gain 63.
- Preamble saturation: preamble_counter_mode=1 with 200 samples -> preamble_counter holds 127; preamble_counter_mode=0 one cycle -> preamble_counter=0, done cleared.

Source files
------------

// File: rtl/agc_pkg.sv
// Shared AGC constants: counter widths, terminal counts and the controller state encoding.
package agc_pkg;

    localparam int CNT_W   = 4;
    localparam int PRE_W   = 8;
    localparam int CNT1_TC = 15;
    localparam int CNT2_TC = 15;
    localparam int PRE_TC  = 127;

    // Controller state encoding; the controller and this datapath must agree on it.
    typedef enum logic [2:0] {
        ST_RESET    = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_DETECT   = 3'd2,
        ST_ADJUST   = 3'd3,
        ST_SETTLE   = 3'd4,
        ST_LOCK     = 3'd5
    } agc_state_t;

endpackage

// File: rtl/agc_sat_counter.sv
// Up-counter that saturates at MAX; a synchronous clear takes priority over counting.
module agc_sat_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && (count != MAX_V))
            count <= count + WIDTH'(1);
    end

endmodule

// File: rtl/agc_datapath.sv
// AGC datapath: window statistics, settle/preamble counters, sticky done flag and the gain code.
module agc_datapath
    import agc_pkg::*;
#(
    parameter int GAIN_W    = 6,
    parameter int GAIN_INIT = 32,
    parameter int GAIN_MIN  = 0,
    parameter int GAIN_MAX  = 63,
    parameter int GAIN_STEP = 1,
    parameter int HI_LIMIT  = 3,
    parameter int LO_LIMIT  = 10
) (
    input  logic              clk,
    input  logic              RESETn,
    input  logic              sample_valid,
    input  logic              sample_hi,
    input  logic              sample_lo,
    input  logic              counter1_mode,
    input  logic              counter2_mode,
    input  logic              preamble_counter_mode,
    input  logic              detect_mode,
    input  logic              adjust,
    input  logic              up_dn,
    output logic [CNT_W-1:0]  counter1,
    output logic [CNT_W-1:0]  counter2,
    output logic [PRE_W-1:0]  preamble_counter,
    output logic              indicator,
    output logic              done,
    output logic [GAIN_W-1:0] gain
);

    localparam logic [GAIN_W-1:0] GAIN_RST = GAIN_W'(GAIN_INIT);
    localparam logic [GAIN_W:0]   MAX_X    = (GAIN_W+1)'(GAIN_MAX);
    localparam logic [GAIN_W:0]   MIN_X    = (GAIN_W+1)'(GAIN_MIN);
    localparam logic [GAIN_W:0]   STEP_X   = (GAIN_W+1)'(GAIN_STEP);
    localparam logic [CNT_W-1:0]  HI_LIM_V = CNT_W'(HI_LIMIT);
    localparam logic [CNT_W-1:0]  LO_LIM_V = CNT_W'(LO_LIMIT);
    localparam logic [CNT_W-1:0]  STAT_TC  = CNT_W'(CNT1_TC);
    localparam logic [CNT_W-1:0]  C1_LAST  = CNT_W'(CNT1_TC - 1);

    logic [CNT_W-1:0] hi_cnt, lo_cnt;
    logic [CNT_W-1:0] hi_post, lo_post;
    logic [GAIN_W:0]  gain_x, gain_up, gain_dn;
    logic [GAIN_W-1:0] gain_next;
    logic accepted, inc_hi, inc_lo, win_close, win_ok;
    logic step_en, rail_hit;

    assign accepted = sample_valid & counter1_mode;
    assign inc_hi   = accepted & sample_hi;
    assign inc_lo   = accepted & ~sample_hi & sample_lo;

    agc_sat_counter #(.WIDTH(CNT_W), .MAX(CNT1_TC)) u_counter1 (
        .clk(clk), .rst_n(RESETn), .clr(~counter1_mode), .inc(sample_valid), .count(counter1));

    agc_sat_counter #(.WIDTH(CNT_W), .MAX(CNT2_TC)) u_counter2 (
        .clk(clk), .rst_n(RESETn), .clr(~counter2_mode), .inc(1'b1), .count(counter2));

    agc_sat_counter #(.WIDTH(PRE_W), .MAX(PRE_TC)) u_preamble (
        .clk(clk), .rst_n(RESETn), .clr(~preamble_counter_mode), .inc(sample_valid),
        .count(preamble_counter));

    agc_sat_counter #(.WIDTH(CNT_W), .MAX(CNT1_TC)) u_hi_cnt (
        .clk(clk), .rst_n(RESETn), .clr(~detect_mode), .inc(inc_hi), .count(hi_cnt));

    agc_sat_counter #(.WIDTH(CNT_W), .MAX(CNT1_TC)) u_lo_cnt (
        .clk(clk), .rst_n(RESETn), .clr(~detect_mode), .inc(inc_lo), .count(lo_cnt));

    // Window verdict uses the counts as they will be after this edge's sample.
    always_comb begin
        hi_post = hi_cnt;
        lo_post = lo_cnt;
        if (!detect_mode) begin
            hi_post = '0;
            lo_post = '0;
        end else begin
            if (inc_hi && (hi_cnt != STAT_TC)) hi_post = hi_cnt + CNT_W'(1);
            if (inc_lo && (lo_cnt != STAT_TC)) lo_post = lo_cnt + CNT_W'(1);
        end
    end

    assign win_close = accepted & (counter1 == C1_LAST);
    assign win_ok    = (hi_post <= HI_LIM_V) & (lo_post <= LO_LIM_V);

    assign gain_x  = {1'b0, gain};
    assign gain_up = gain_x + STEP_X;
    assign gain_dn = gain_x - STEP_X;

    always_comb begin
        gain_next = gain;
        if (up_dn)
            gain_next = (gain_up > MAX_X) ? MAX_X[GAIN_W-1:0] : gain_up[GAIN_W-1:0];
        else
            gain_next = (gain_x < MIN_X + STEP_X) ? MIN_X[GAIN_W-1:0] : gain_dn[GAIN_W-1:0];
    end

    // One step per adjust phase: only on the first settle cycle, and never once locked.
    assign step_en  = adjust & counter2_mode & (counter2 == '0) & ~done;
    assign rail_hit = step_en & (up_dn ? (gain_x >= MAX_X) : (gain_x <= MIN_X));

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            indicator <= 1'b0;
            done      <= 1'b0;
            gain      <= GAIN_RST;
        end else begin
            if (win_close)
                indicator <= (hi_post > HI_LIM_V);
            if (!preamble_counter_mode)
                done <= 1'b0;
            else if ((win_close && win_ok) || rail_hit)
                done <= 1'b1;
            if (step_en && !rail_hit)
                gain <= gain_next;
        end
    end

endmodule
